// File: rtl/pic_pkg.sv
// Shared 8259A definitions: IR level constants and the vector helpers used
// for priority rotation. Also imported by the control logic block.
package pic_pkg;

    localparam int         PIC_LEVELS = 8;

    localparam logic [2:0] IR0 = 3'd0;
    localparam logic [2:0] IR1 = 3'd1;
    localparam logic [2:0] IR2 = 3'd2;
    localparam logic [2:0] IR3 = 3'd3;
    localparam logic [2:0] IR4 = 3'd4;
    localparam logic [2:0] IR5 = 3'd5;
    localparam logic [2:0] IR6 = 3'd6;
    localparam logic [2:0] IR7 = 3'd7;

    // Circular right rotation of an 8-bit vector by n places.
    function automatic logic [7:0] rotate_right8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] doubled;
        doubled = {v, v} >> n;
        return doubled[7:0];
    endfunction

    // Circular left rotation of an 8-bit vector by n places.
    function automatic logic [7:0] rotate_left8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] doubled;
        doubled = {v, v} << n;
        return doubled[15:8];
    endfunction

    // Index of the set bit of a one-hot vector (0 for an all-zero vector).
    function automatic logic [2:0] onehot8_to_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < PIC_LEVELS; k++) begin
            if (v[k]) begin
                idx = idx | 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_priority_select.sv
// Picks the highest-priority set bit of a request vector under the current
// rotation. The bit just above 'lowest' is the most important one, so the
// vector is rotated to put it at bit 0, the lowest set bit is isolated, and
// the result is rotated back into IR numbering.
module pic_priority_select
    import pic_pkg::*;
(
    input  logic [7:0] vector,
    input  logic [2:0] lowest,
    output logic [7:0] winner
);

    logic [2:0] w_shift;
    logic [7:0] w_rotated;
    logic [7:0] w_isolated;

    assign w_shift    = lowest + 3'd1;
    assign w_rotated  = rotate_right8(vector, w_shift);
    // Two's-complement trick keeps only the least significant set bit.
    assign w_isolated = w_rotated & (~w_rotated + 8'd1);
    assign winner     = rotate_left8(w_isolated, w_shift);

endmodule

// File: rtl/pic_priority_resolver.sv
// 8259A interrupt request front end: IRR capture in edge or level mode,
// IMR masking, ISR set/clear and fixed/rotating priority resolution that
// feeds the control logic block.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter logic [2:0] RESET_PRIORITY = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir_in,
    input  logic       level_or_edge_triggered,
    input  logic [7:0] interrupt_mask,
    input  logic       special_mask_mode,
    input  logic       freeze,
    input  logic       latch_isr,
    input  logic [7:0] end_of_interrupt,
    input  logic       rotate_on_eoi,
    input  logic       priority_load,
    input  logic [2:0] priority_level,
    output logic [7:0] interrupt,
    output logic       int_req,
    output logic [7:0] highest_level_in_service,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [7:0] r_interrupt;
    logic       r_int_req;
    logic [7:0] r_ir_prev;
    logic [2:0] r_lowest;

    logic [2:0] w_shift;
    logic [7:0] w_candidate;
    logic [7:0] w_eff_isr;
    logic [7:0] w_req_winner;
    logic [7:0] w_isr_winner;
    logic [7:0] w_req_rot;
    logic [7:0] w_isr_rot;
    logic [7:0] w_interrupt_next;
    logic [7:0] w_irr_next;
    logic [7:0] w_isr_next;
    logic [7:0] w_eoi_rot;
    logic [7:0] w_eoi_top;
    logic [2:0] w_eoi_idx;
    logic [2:0] w_lowest_next;

    assign w_shift     = r_lowest + 3'd1;
    assign w_candidate = r_irr & ~interrupt_mask;
    // In special mask mode a masked in-service level no longer blocks others.
    assign w_eff_isr   = special_mask_mode ? (r_isr & ~interrupt_mask) : r_isr;

    pic_priority_select u_req_select (
        .vector (w_candidate),
        .lowest (r_lowest),
        .winner (w_req_winner)
    );

    pic_priority_select u_isr_select (
        .vector (w_eff_isr),
        .lowest (r_lowest),
        .winner (w_isr_winner)
    );

    // In rotated space a smaller one-hot value means a higher priority, so a
    // plain magnitude compare tells whether the request outranks the ISR.
    assign w_req_rot = rotate_right8(w_req_winner, w_shift);
    assign w_isr_rot = rotate_right8(w_isr_winner, w_shift);

    // Request wins only when strictly above the highest in-service level.
    always_comb begin
        w_interrupt_next = 8'h00;
        if ((w_req_rot != 8'h00) && ((w_isr_rot == 8'h00) || (w_req_rot < w_isr_rot))) begin
            w_interrupt_next = w_req_winner;
        end
    end

    // Per-level IRR capture; the latch_isr clear overrides freeze and any new set.
    generate
        for (genvar gi = 0; gi < PIC_LEVELS; gi++) begin : g_irr
            assign w_irr_next[gi] =
                (latch_isr & r_interrupt[gi]) ? 1'b0 :
                freeze                        ? r_irr[gi] :
                level_or_edge_triggered       ? ir_in[gi] :
                (ir_in[gi] & (r_irr[gi] | ~r_ir_prev[gi]));
        end
    endgenerate

    // Clear first, then set, so a level latched in the same cycle stays set.
    assign w_isr_next = (r_isr & ~end_of_interrupt) | (latch_isr ? r_interrupt : 8'h00);

    // Highest-priority level named by an EOI becomes the new lowest priority.
    assign w_eoi_rot = rotate_right8(end_of_interrupt, w_shift);
    assign w_eoi_top = rotate_left8(w_eoi_rot & (~w_eoi_rot + 8'd1), w_shift);
    assign w_eoi_idx = onehot8_to_idx(w_eoi_top);

    // Lowest-priority register update; an explicit set-priority load wins.
    always_comb begin
        w_lowest_next = r_lowest;
        if (priority_load) begin
            w_lowest_next = priority_level;
        end else if (rotate_on_eoi && (|end_of_interrupt)) begin
            w_lowest_next = w_eoi_idx;
        end
    end

    // State registers; interrupt and INT are held while an INTA sequence freezes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irr       <= 8'h00;
            r_isr       <= 8'h00;
            r_interrupt <= 8'h00;
            r_int_req   <= 1'b0;
            r_ir_prev   <= 8'h00;
            r_lowest    <= RESET_PRIORITY;
        end else begin
            r_irr     <= w_irr_next;
            r_isr     <= w_isr_next;
            r_ir_prev <= ir_in;
            r_lowest  <= w_lowest_next;
            if (!freeze) begin
                r_interrupt <= w_interrupt_next;
                r_int_req   <= |w_interrupt_next;
            end
        end
    end

    assign interrupt                = r_interrupt;
    assign int_req                  = r_int_req;
    assign highest_level_in_service = w_isr_winner;
    assign irr                      = r_irr;
    assign isr                      = r_isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Bench for pic_priority_resolver: a rank-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pic_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir_in;
    logic       level_or_edge_triggered;
    logic [7:0] interrupt_mask;
    logic       special_mask_mode;
    logic       freeze;
    logic       latch_isr;
    logic [7:0] end_of_interrupt;
    logic       rotate_on_eoi;
    logic       priority_load;
    logic [2:0] priority_level;
    logic [7:0] interrupt;
    logic       int_req;
    logic [7:0] highest_level_in_service;
    logic [7:0] irr;
    logic [7:0] isr;

    always #5 clk = ~clk;

    pic_priority_resolver #(.RESET_PRIORITY(3'd7)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .ir_in                    (ir_in),
        .level_or_edge_triggered  (level_or_edge_triggered),
        .interrupt_mask           (interrupt_mask),
        .special_mask_mode        (special_mask_mode),
        .freeze                   (freeze),
        .latch_isr                (latch_isr),
        .end_of_interrupt         (end_of_interrupt),
        .rotate_on_eoi            (rotate_on_eoi),
        .priority_load            (priority_load),
        .priority_level           (priority_level),
        .interrupt                (interrupt),
        .int_req                  (int_req),
        .highest_level_in_service (highest_level_in_service),
        .irr                      (irr),
        .isr                      (isr)
    );

    // Reference model state
    logic [7:0] m_irr, m_isr, m_int, m_prev;
    logic       m_req;
    int         m_low;
    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;

    // Priority rank of level i: 0 is the most important.
    function automatic int rank(input int i, input int low);
        return (i - low - 1 + 16) % 8;
    endfunction

    // Level with the best rank among set bits, or -1 if none.
    function automatic int best(input logic [7:0] v, input int low);
        int b;
        int br;
        b  = -1;
        br = 99;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && rank(i, low) < br) begin
                br = rank(i, low);
                b  = i;
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] hot(input int b);
        logic [7:0] one;
        one = 8'h01;
        return (b < 0) ? 8'h00 : (one << b);
    endfunction

    // Advance the model by one clock using the inputs present at this edge.
    task automatic model_step();
        int         rq;
        int         is;
        logic [7:0] nint;
        logic [7:0] nirr;
        logic [7:0] eff;
        if (reset) begin
            m_irr  = 8'h00;
            m_isr  = 8'h00;
            m_int  = 8'h00;
            m_req  = 1'b0;
            m_prev = 8'h00;
            m_low  = 7;
        end else begin
            eff  = special_mask_mode ? (m_isr & ~interrupt_mask) : m_isr;
            rq   = best(m_irr & ~interrupt_mask, m_low);
            is   = best(eff, m_low);
            nint = (rq >= 0 && (is < 0 || rank(rq, m_low) < rank(is, m_low))) ? hot(rq) : 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (freeze)                       nirr[i] = m_irr[i];
                else if (level_or_edge_triggered) nirr[i] = ir_in[i];
                else if (!ir_in[i])               nirr[i] = 1'b0;
                else if (!m_prev[i])              nirr[i] = 1'b1;
                else                              nirr[i] = m_irr[i];
            end
            if (latch_isr) nirr = nirr & ~m_int;
            m_isr = (m_isr & ~end_of_interrupt) | (latch_isr ? m_int : 8'h00);
            m_irr = nirr;
            if (priority_load)                               m_low = int'(priority_level);
            else if (rotate_on_eoi && end_of_interrupt != 0) m_low = best(end_of_interrupt, m_low);
            if (!freeze) begin
                m_int = nint;
                m_req = (nint != 8'h00);
            end
            m_prev = ir_in;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %02h expected %02h", name, cycle, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] eff;
        eff = special_mask_mode ? (m_isr & ~interrupt_mask) : m_isr;
        check("interrupt", interrupt, m_int);
        check("int_req", {7'b0, int_req}, {7'b0, m_req});
        check("hlis", highest_level_in_service, hot(best(eff, m_low)));
        check("irr", irr, m_irr);
        check("isr", isr, m_isr);
    endtask

    // One clock: update model, wait past the edge, compare, log the transaction.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #2;
        cycle++;
        compare_all();
        $display("cyc %0d rst=%0b ir=%02h lt=%0b m=%02h smm=%0b frz=%0b lat=%0b eoi=%02h | irr=%02h isr=%02h int=%02h req=%0b hlis=%02h",
                 cycle, reset, ir_in, level_or_edge_triggered, interrupt_mask, special_mask_mode,
                 freeze, latch_isr, end_of_interrupt, irr, isr, interrupt, int_req,
                 highest_level_in_service);
    endtask

    initial begin
        reset = 1'b1; ir_in = 8'h00; level_or_edge_triggered = 1'b0; interrupt_mask = 8'h00;
        special_mask_mode = 1'b0; freeze = 1'b0; latch_isr = 1'b0; end_of_interrupt = 8'h00;
        rotate_on_eoi = 1'b0; priority_load = 1'b0; priority_level = 3'd0;
        cyc(); cyc();
        check("rst_int", interrupt, 8'h00);
        check("rst_irr", irr, 8'h00);
        reset = 1'b0;

        // 1: edge on IR3
        ir_in = 8'h08; cyc();
        check("t1_irr", irr, 8'h08);
        cyc();
        check("t1_int", interrupt, 8'h08);
        check("t1_req", {7'b0, int_req}, 8'h01);
        ir_in = 8'h00; cyc(); cyc();
        check("t1_drop", interrupt, 8'h00);

        // 2: IR5 and IR2 together, then latch IR2
        ir_in = 8'h24; cyc(); cyc();
        check("t2_int", interrupt, 8'h04);
        latch_isr = 1'b1; cyc(); latch_isr = 1'b0;
        check("t2_isr", isr, 8'h04);
        check("t2_irr", irr, 8'h20);
        cyc();
        check("t2_blk", interrupt, 8'h00);
        check("t2_hlis", highest_level_in_service, 8'h04);

        // 3: rotating EOI on IR2 makes IR3 top priority
        ir_in = 8'h2C; cyc();
        end_of_interrupt = 8'h04; rotate_on_eoi = 1'b1; cyc();
        end_of_interrupt = 8'h00; rotate_on_eoi = 1'b0;
        check("t3_isr", isr, 8'h00);
        cyc();
        check("t3_int", interrupt, 8'h08);

        // 4: set priority, lowest = 4
        ir_in = 8'h00; cyc(); cyc();
        priority_load = 1'b1; priority_level = 3'd4; ir_in = 8'h42; cyc();
        priority_load = 1'b0; cyc();
        check("t4_int", interrupt, 8'h40);

        // 5: special mask mode
        priority_load = 1'b1; priority_level = 3'd7; cyc();
        priority_load = 1'b0; cyc();
        check("t5_int1", interrupt, 8'h02);
        latch_isr = 1'b1; cyc(); latch_isr = 1'b0; cyc();
        check("t5_blk", interrupt, 8'h00);
        ir_in = 8'h52; interrupt_mask = 8'h02; special_mask_mode = 1'b1; cyc(); cyc();
        check("t5_smm", interrupt, 8'h10);
        special_mask_mode = 1'b0; cyc();
        check("t5_nosmm", interrupt, 8'h00);
        check("t5_hlis", highest_level_in_service, 8'h02);

        // 6: level mode, reset mid-request
        interrupt_mask = 8'h00; end_of_interrupt = 8'h02; ir_in = 8'h00;
        level_or_edge_triggered = 1'b1; cyc();
        end_of_interrupt = 8'h00; ir_in = 8'h80; cyc(); cyc();
        check("t6_int", interrupt, 8'h80);
        reset = 1'b1; cyc();
        check("t6_rst_int", interrupt, 8'h00);
        check("t6_rst_irr", irr, 8'h00);
        reset = 1'b0; cyc(); cyc();
        check("t6_rel", interrupt, 8'h80);

        // Freeze holds IRR and interrupt, latch still clears
        freeze = 1'b1; ir_in = 8'h81; cyc();
        check("frz_irr", irr, 8'h80);
        check("frz_int", interrupt, 8'h80);
        latch_isr = 1'b1; cyc(); latch_isr = 1'b0;
        check("frz_lat_irr", irr, 8'h00);
        check("frz_lat_isr", isr, 8'h80);
        freeze = 1'b0; cyc(); cyc();
        check("frz_rel", interrupt, 8'h01);
        end_of_interrupt = 8'hFF; cyc(); end_of_interrupt = 8'h00;
        check("eoi_all", isr, 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset            = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 2) == 0) ir_in = ir_in ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 30) == 0) level_or_edge_triggered = ~level_or_edge_triggered;
            if ($urandom_range(0, 10) == 0) interrupt_mask = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) special_mask_mode = ~special_mask_mode;
            freeze           = ($urandom_range(0, 5) == 0);
            latch_isr        = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0, 1:    end_of_interrupt = 8'h01 << $urandom_range(0, 7);
                2:       end_of_interrupt = 8'($urandom_range(0, 255));
                default: end_of_interrupt = 8'h00;
            endcase
            rotate_on_eoi    = ($urandom_range(0, 1) == 1);
            priority_load    = ($urandom_range(0, 11) == 0);
            priority_level   = 3'($urandom_range(0, 7));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
